// File: rtl/delta_ctrl_pkg.sv
// Shared constants for the delta layer sequencer: FSM state codes, DMA command
// opcodes and the default output-channel group size.
package delta_ctrl_pkg;

  localparam int DEFAULT_PE_OC = 16;

  typedef enum logic [1:0] {
    OP_LOAD_IN = 2'd0,
    OP_LOAD_W  = 2'd1,
    OP_STORE   = 2'd2
  } cmd_op_e;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_LOAD_IN  = 4'd1;
  localparam state_t ST_WAIT_IN  = 4'd2;
  localparam state_t ST_GROUP    = 4'd3;
  localparam state_t ST_LOAD_W   = 4'd4;
  localparam state_t ST_WAIT_W   = 4'd5;
  localparam state_t ST_CMP_GO   = 4'd6;
  localparam state_t ST_CMP_WAIT = 4'd7;
  localparam state_t ST_STORE    = 4'd8;
  localparam state_t ST_WAIT_ST  = 4'd9;
  localparam state_t ST_ADVANCE  = 4'd10;
  localparam state_t ST_DONE     = 4'd11;

endpackage

// File: rtl/delta_layer_ctrl_if.sv
// DMA command channel between the layer sequencer (master) and the DMA engine
// (slave): one outstanding command, completion signalled by xfer_done.
interface delta_layer_ctrl_if
  import delta_ctrl_pkg::*;
#(
  parameter int OCW = 10
);

  logic           cmd_valid;
  logic           cmd_ready;
  cmd_op_e        cmd_op;
  logic [31:0]    cmd_addr;
  logic [OCW-1:0] cmd_oc_base;
  logic [OCW-1:0] cmd_oc_cnt;
  logic           xfer_done;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_oc_base, cmd_oc_cnt,
    input  cmd_ready, xfer_done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_oc_base, cmd_oc_cnt,
    output cmd_ready, xfer_done
  );

endinterface

// File: rtl/delta_oc_tiler.sv
// Output-channel group walker: tracks the first channel of the current group,
// the group size, and whether the walk has passed the final group.
module delta_oc_tiler
  import delta_ctrl_pkg::*;
#(
  parameter int PE_OC = DEFAULT_PE_OC,
  parameter int OCW   = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           step,
  input  logic [OCW-1:0] oc_num,
  output logic [OCW:0]   oc_base,
  output logic [OCW-1:0] oc_cnt,
  output logic           last
);

  localparam logic [OCW:0] STEP = (OCW+1)'(PE_OC);

  logic [OCW:0] oc_base_q, oc_base_d;
  logic [OCW:0] remaining;

  always_comb begin
    oc_base_d = oc_base_q;
    if (clear) begin
      oc_base_d = '0;
    end else if (step) begin
      oc_base_d = oc_base_q + STEP;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oc_base_q <= '0;
    end else begin
      oc_base_q <= oc_base_d;
    end
  end

  // The extra base bit lets the walk step past OC_Num without wrapping.
  assign last      = (oc_base_q >= {1'b0, oc_num});
  assign remaining = {1'b0, oc_num} - oc_base_q;
  assign oc_base   = oc_base_q;

  always_comb begin
    oc_cnt = '0;
    if (!last) begin
      oc_cnt = (remaining > STEP) ? STEP[OCW-1:0] : remaining[OCW-1:0];
    end
  end

endmodule

// File: rtl/delta_layer_ctrl.sv
// Layer sequencer: captures a layer config, then walks output-channel groups
// issuing DMA and PE commands. Define DELTA_CTRL_PERF_EN for perf counters.
module delta_layer_ctrl
  import delta_ctrl_pkg::*;
#(
  parameter int PE_OC = DEFAULT_PE_OC,
  parameter int OCW   = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               ack,
  output logic               done,
  output logic               busy,
  input  logic [OCW-1:0]     IC_Num,
  input  logic [OCW-1:0]     OC_Num,
  input  logic [7:0]         ORC_Size,
  input  logic               load_input,
  input  logic               store_output,
  input  logic [31:0]        weight_start_address,
  input  logic [31:0]        input_start_address,
  input  logic [31:0]        output_start_address,
  delta_layer_ctrl_if.master dma,
  output logic               cmp_start,
  output logic [OCW-1:0]     cmp_ic,
  input  logic               cmp_done
`ifdef DELTA_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_stall
`endif
);

  typedef struct packed {
    logic [OCW-1:0] ic;
    logic [OCW-1:0] oc;
    logic [7:0]     orc;
    logic           store_out;
    logic [31:0]    waddr;
    logic [31:0]    iaddr;
    logic [31:0]    oaddr;
  } cfg_t;

  state_t         state_q, state_d;
  cfg_t           cfg_q, cfg_d;
  logic           ack_q, ack_d;
  logic           tiler_clear, tiler_step;
  logic [OCW:0]   tile_base;
  logic [OCW-1:0] tile_cnt;
  logic           tiles_last;
  logic [31:0]    store_offset;

  delta_oc_tiler #(
    .PE_OC (PE_OC),
    .OCW   (OCW)
  ) u_tiler (
    .clock   (clock),
    .reset   (reset),
    .clear   (tiler_clear),
    .step    (tiler_step),
    .oc_num  (cfg_q.oc),
    .oc_base (tile_base),
    .oc_cnt  (tile_cnt),
    .last    (tiles_last)
  );

  // load_input only steers the first transition, so it is not kept in cfg.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    ack_d       = 1'b0;
    tiler_clear = 1'b0;
    tiler_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d.ic        = IC_Num;
          cfg_d.oc        = OC_Num;
          cfg_d.orc       = ORC_Size;
          cfg_d.store_out = store_output;
          cfg_d.waddr     = weight_start_address;
          cfg_d.iaddr     = input_start_address;
          cfg_d.oaddr     = output_start_address;
          ack_d           = 1'b1;
          tiler_clear     = 1'b1;
          state_d         = load_input ? ST_LOAD_IN : ST_GROUP;
        end
      end
      ST_LOAD_IN: begin
        if (dma.cmd_ready) begin
          state_d = dma.xfer_done ? ST_GROUP : ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (dma.xfer_done) begin
          state_d = ST_GROUP;
        end
      end
      ST_GROUP: begin
        state_d = tiles_last ? ST_DONE : ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (dma.cmd_ready) begin
          state_d = dma.xfer_done ? ST_CMP_GO : ST_WAIT_W;
        end
      end
      ST_WAIT_W: begin
        if (dma.xfer_done) begin
          state_d = ST_CMP_GO;
        end
      end
      ST_CMP_GO: begin
        state_d = ST_CMP_WAIT;
      end
      ST_CMP_WAIT: begin
        if (cmp_done) begin
          state_d = cfg_q.store_out ? ST_STORE : ST_ADVANCE;
        end
      end
      ST_STORE: begin
        if (dma.cmd_ready) begin
          state_d = dma.xfer_done ? ST_ADVANCE : ST_WAIT_ST;
        end
      end
      ST_WAIT_ST: begin
        if (dma.xfer_done) begin
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        tiler_step = 1'b1;
        state_d    = ST_GROUP;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ack_q   <= ack_d;
    end
  end

  assign store_offset = 32'(tile_base) * 32'(cfg_q.orc) * 32'(cfg_q.orc);

  // Command fields depend only on registered state, so they hold through a stall.
  always_comb begin
    dma.cmd_valid   = 1'b0;
    dma.cmd_op      = OP_LOAD_IN;
    dma.cmd_addr    = '0;
    dma.cmd_oc_base = '0;
    dma.cmd_oc_cnt  = '0;
    case (state_q)
      ST_LOAD_IN: begin
        dma.cmd_valid = 1'b1;
        dma.cmd_addr  = cfg_q.iaddr;
      end
      ST_LOAD_W: begin
        dma.cmd_valid   = 1'b1;
        dma.cmd_op      = OP_LOAD_W;
        dma.cmd_addr    = cfg_q.waddr;
        dma.cmd_oc_base = tile_base[OCW-1:0];
        dma.cmd_oc_cnt  = tile_cnt;
      end
      ST_STORE: begin
        dma.cmd_valid   = 1'b1;
        dma.cmd_op      = OP_STORE;
        dma.cmd_addr    = cfg_q.oaddr + store_offset;
        dma.cmd_oc_base = tile_base[OCW-1:0];
        dma.cmd_oc_cnt  = tile_cnt;
      end
      default: begin
        dma.cmd_valid = 1'b0;
      end
    endcase
  end

  assign ack       = ack_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign cmp_start = (state_q == ST_CMP_GO);
  assign cmp_ic    = cfg_q.ic;

`ifdef DELTA_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if (ack_d) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) begin
        perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if (dma.cmd_valid && !dma.cmd_ready && (perf_stall_q != '1)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_delta_layer_ctrl.sv
// Self-checking bench for delta_layer_ctrl: randomized DMA/PE responders checked
// against a command-list model built from the layer configuration.
module tb_delta_layer_ctrl;
  import delta_ctrl_pkg::*;

  localparam int PE_OC = 16;
  localparam int OCW   = 10;

  typedef struct {
    logic [1:0]     op;
    logic [31:0]    addr;
    logic [OCW-1:0] base;
    logic [OCW-1:0] cnt;
  } cmd_t;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           ack, done, busy;
  logic [OCW-1:0] ic_num, oc_num;
  logic [7:0]     orc_size;
  logic           load_input, store_output;
  logic [31:0]    waddr, iaddr, oaddr;
  logic           cmp_start;
  logic [OCW-1:0] cmp_ic;
  logic           cmp_done;
`ifdef DELTA_CTRL_PERF_EN
  logic [31:0]    perf_cycles, perf_stall;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  delta_layer_ctrl_if #(.OCW(OCW)) dma ();

  delta_layer_ctrl #(
    .PE_OC (PE_OC),
    .OCW   (OCW)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .ack                  (ack),
    .done                 (done),
    .busy                 (busy),
    .IC_Num               (ic_num),
    .OC_Num               (oc_num),
    .ORC_Size             (orc_size),
    .load_input           (load_input),
    .store_output         (store_output),
    .weight_start_address (waddr),
    .input_start_address  (iaddr),
    .output_start_address (oaddr),
    .dma                  (dma),
    .cmp_start            (cmp_start),
    .cmp_ic               (cmp_ic),
    .cmp_done             (cmp_done)
`ifdef DELTA_CTRL_PERF_EN
    ,
    .perf_cycles          (perf_cycles),
    .perf_stall           (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic set_cfg(input int oc, input int orc, input bit li, input bit so);
    oc_num       = OCW'(oc);
    orc_size     = 8'(orc);
    load_input   = li;
    store_output = so;
    ic_num       = OCW'($urandom_range(1, 1023));
    waddr        = $urandom;
    iaddr        = $urandom;
    oaddr        = $urandom;
  endtask

  // Runs one full layer with a randomized DMA engine and PE array.
  task automatic run_layer(input int ready_pct, input bit stall_w, input bit restart,
                           input int max_xfer, output int layer_cycles);
    cmd_t        exp_q[$];
    cmd_t        e, got, prev_cmd;
    int          groups = 0, ack_cnt = 0, done_cnt = 0, cmp_cnt = 0, cyc = 0;
    int          stall_cycles = 0, busy_cycles = 0;
    int          xfer_cd = 0, cmp_cd = 0, stall_left = -1;
    bit          in_layer = 0, outstanding = 0, pe_pending = 0, prev_wait = 0;
    bit          finished = 0, rdy;
    logic [31:0] off;

    if (load_input) begin
      e.op = 2'd0; e.addr = iaddr; e.base = '0; e.cnt = '0;
      exp_q.push_back(e);
    end
    for (int b = 0; b < int'(oc_num); b += PE_OC) begin
      e.op   = 2'd1;
      e.addr = waddr;
      e.base = OCW'(b);
      e.cnt  = OCW'(((int'(oc_num) - b) < PE_OC) ? (int'(oc_num) - b) : PE_OC);
      exp_q.push_back(e);
      if (store_output) begin
        off    = 32'(b) * 32'(orc_size) * 32'(orc_size);
        e.op   = 2'd2;
        e.addr = oaddr + off;
        exp_q.push_back(e);
      end
      groups++;
    end

    start = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      dma.xfer_done = 1'b0;
      cmp_done      = 1'b0;

      if (ack) begin
        n_cmp++;
        if (ack_cnt != 0) begin
          n_fail++;
          $display("[TB] FAIL extra_ack: ack count %0d, required 1", ack_cnt + 1);
        end
        ack_cnt++;
        in_layer = 1'b1;
        start    = 1'b0;
      end

      n_cmp++;
      if (busy !== in_layer) begin
        n_fail++;
        $display("[TB] FAIL busy: got %b, required %b (cycle %0d)", busy, in_layer, cyc);
      end
      if (in_layer) busy_cycles++;

      if (done) begin
        done_cnt++;
        in_layer = 1'b0;
        finished = 1'b1;
      end

      if (cmp_start) begin
        cmp_cnt++;
        n_cmp++;
        if (cmp_ic !== ic_num || outstanding || pe_pending) begin
          n_fail++;
          $display("[TB] FAIL cmp_start: cmp_ic=%0d required %0d, dma_busy=%b pe_busy=%b",
                   cmp_ic, ic_num, outstanding, pe_pending);
        end
        pe_pending = 1'b1;
        cmp_cd     = $urandom_range(1, 4);
        if ($urandom_range(0, 1) == 1) cmp_done = 1'b1;
        if (restart) start = 1'b1;
      end else if (pe_pending) begin
        cmp_cd--;
        if (cmp_cd == 0) begin
          cmp_done   = 1'b1;
          pe_pending = 1'b0;
        end
      end

      if (outstanding) begin
        xfer_cd--;
        if (xfer_cd == 0) begin
          dma.xfer_done = 1'b1;
          outstanding   = 1'b0;
        end
      end

      got.op   = dma.cmd_op;
      got.addr = dma.cmd_addr;
      got.base = dma.cmd_oc_base;
      got.cnt  = dma.cmd_oc_cnt;

      if (prev_wait) begin
        n_cmp++;
        if (!dma.cmd_valid || got.op !== prev_cmd.op || got.addr !== prev_cmd.addr ||
            got.base !== prev_cmd.base || got.cnt !== prev_cmd.cnt) begin
          n_fail++;
          $display("[TB] FAIL stall_stable: valid=%b op=%0d addr=%h, required valid=1 op=%0d addr=%h",
                   dma.cmd_valid, got.op, got.addr, prev_cmd.op, prev_cmd.addr);
        end
      end

      if (dma.cmd_valid) begin
        n_cmp++;
        if (outstanding || pe_pending) begin
          n_fail++;
          $display("[TB] FAIL overlap: cmd issued with dma_busy=%b pe_busy=%b, required both 0",
                   outstanding, pe_pending);
        end
        if (stall_w && got.op == 2'd1 && stall_left < 0) stall_left = 5;
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(1, 100) <= ready_pct);
        end
        dma.cmd_ready = rdy;
        if (rdy) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL cmd_extra: got op=%0d addr=%h, required no command", got.op, got.addr);
          end else begin
            e = exp_q.pop_front();
            if (got.op !== e.op || got.addr !== e.addr || got.base !== e.base || got.cnt !== e.cnt) begin
              n_fail++;
              $display("[TB] FAIL cmd: got op=%0d addr=%h base=%0d cnt=%0d, required op=%0d addr=%h base=%0d cnt=%0d",
                       got.op, got.addr, got.base, got.cnt, e.op, e.addr, e.base, e.cnt);
            end
          end
          outstanding = 1'b1;
          xfer_cd     = $urandom_range(0, max_xfer);
          if (xfer_cd == 0) begin
            dma.xfer_done = 1'b1;
            outstanding   = 1'b0;
          end
          prev_wait = 1'b0;
        end else begin
          stall_cycles++;
          prev_wait = 1'b1;
          prev_cmd  = got;
        end
      end else begin
        dma.cmd_ready = 1'($urandom_range(0, 1));
        prev_wait     = 1'b0;
      end
    end

    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL layer_timeout: no done after %0d cycles, required done", cyc);
    end
    n_cmp++;
    if (ack_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL ack_count: got %0d, required 1", ack_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("[TB] FAIL done_count: got %0d, required 1", done_cnt);
    end
    n_cmp++;
    if (cmp_cnt != groups) begin
      n_fail++;
      $display("[TB] FAIL cmp_count: got %0d, required %0d", cmp_cnt, groups);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL cmd_missing: %0d commands never issued, required 0", exp_q.size());
    end

    @(negedge clock);
    dma.xfer_done = 1'b0;
    cmp_done      = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_done: busy=%b done=%b, required 0 0", busy, done);
    end
`ifdef DELTA_CTRL_PERF_EN
    n_cmp++;
    if (perf_cycles !== 32'(busy_cycles)) begin
      n_fail++;
      $display("[TB] FAIL perf_cycles: got %0d, required %0d", perf_cycles, busy_cycles);
    end
    n_cmp++;
    if (perf_stall !== 32'(stall_cycles)) begin
      n_fail++;
      $display("[TB] FAIL perf_stall: got %0d, required %0d", perf_stall, stall_cycles);
    end
`endif
    layer_cycles = busy_cycles;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    start         = 1'b0;
    cmp_done      = 1'b0;
    dma.cmd_ready = 1'b0;
    dma.xfer_done = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({ack, done, busy, cmp_start} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: ack/done/busy/cmp_start=%b, required 0000", {ack, done, busy, cmp_start});
    end
    n_cmp++;
    if ({dma.cmd_valid, dma.cmd_op, dma.cmd_addr, dma.cmd_oc_base, dma.cmd_oc_cnt, cmp_ic} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_cmd: valid=%b addr=%h cmp_ic=%0d, required all 0",
               dma.cmd_valid, dma.cmd_addr, cmp_ic);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({ack, busy, dma.cmd_valid} !== 3'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: ack/busy/valid=%b, required 000", {ack, busy, dma.cmd_valid});
    end
  endtask

  task automatic test_basic_layer();
    int cyc;
    set_cfg(40, 8, 1, 1);
    run_layer(100, 0, 0, 3, cyc);
  endtask

  task automatic test_zero_layer();
    int cyc;
    set_cfg(0, 5, 0, 1);
    run_layer(100, 0, 0, 2, cyc);
    n_cmp++;
    if (cyc < 2 || cyc > 3) begin
      n_fail++;
      $display("[TB] FAIL zero_latency: busy for %0d cycles, required 2..3", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    set_cfg(20, 4, 0, 0);
    run_layer(100, 1, 0, 2, cyc);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    set_cfg(32, 3, 0, 1);
    run_layer(100, 0, 1, 2, cyc);
    run_layer(100, 0, 0, 2, cyc);
  endtask

  task automatic test_same_cycle_completion();
    int cyc;
    set_cfg(16, 2, 1, 1);
    run_layer(100, 0, 0, 0, cyc);
  endtask

  task automatic test_reset_mid_op();
    bit found = 1'b0;
    bit seen  = 1'b0;
    set_cfg(20, 5, 0, 0);
    dma.cmd_ready = 1'b0;
    start         = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (ack) start = 1'b0;
      if (dma.cmd_valid && dma.cmd_op == OP_LOAD_W) begin
        dma.cmd_ready = 1'b1;
        found         = 1'b1;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL midop_reach: LOAD_W seen=%b, required 1", found);
    end
    @(negedge clock);
    dma.cmd_ready = 1'b0;
    reset         = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({ack, done, busy, dma.cmd_valid, cmp_start, cmp_ic, dma.cmd_addr} !== '0) begin
      n_fail++;
      $display("[TB] FAIL midop_reset: ack/done/busy/valid/cmp=%b cmp_ic=%0d, required all 0",
               {ack, done, busy, dma.cmd_valid, cmp_start}, cmp_ic);
    end
    reset = 1'b0;
    @(negedge clock);
    dma.xfer_done = 1'b1;
    cmp_done      = 1'b1;
    @(negedge clock);
    dma.xfer_done = 1'b0;
    cmp_done      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ack || done || busy || dma.cmd_valid || cmp_start) seen = 1'b1;
      @(negedge clock);
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL stray_xfer: activity after reset = %b, required 0", seen);
    end
  endtask

  task automatic test_random_layers();
    int cyc;
    for (int k = 0; k < 10; k++) begin
      set_cfg($urandom_range(0, 70), $urandom_range(1, 255),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_layer($urandom_range(40, 100), 1'($urandom_range(0, 1)), 0, $urandom_range(0, 4), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_layer();
    test_zero_layer();
    test_backpressure();
    test_start_while_busy();
    test_same_cycle_completion();
    test_reset_mid_op();
    test_random_layers();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
